// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: single-outstanding memory reader feeding a prefetch FIFO for decode.
// Define HS32_FETCH_PC_EN to add the instpc output carrying the address of the head word.
module hs32_fetch #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic [31:0] instd,
   input  logic        reqd,
   output logic        ackd,
   input  logic        flush,
   input  logic [31:0] newpc
`ifdef HS32_FETCH_PC_EN
   ,
   output logic [31:0] instpc
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t          state;
   logic [31:0]     pc;
   logic [31:0]     fifoData [DEPTH];
   logic [AW-1:0]   rdPtr;
   logic [AW-1:0]   wrPtr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic [31:0]     target;

`ifdef HS32_FETCH_PC_EN
   logic [31:0]     fifoPc [DEPTH];
`endif

   assign target = {newpc[31:2], 2'b00};
   assign ackd   = (count != '0) & ~flush;
   assign instd  = fifoData[rdPtr];
   assign pop    = reqd & ackd;
   // Only a response to a live request is kept; drops and flush-cycle acks are discarded.
   assign push   = (state == REQ) & mem_ack & ~flush;

`ifdef HS32_FETCH_PC_EN
   assign instpc = (count != '0) ? fifoPc[rdPtr] : 32'h0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         pc       <= RESET_VEC;
         mem_req  <= 1'b0;
         mem_addr <= RESET_VEC;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  pc <= target;
               end else if (count < CW'(DEPTH)) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  pc      <= flush ? target : pc + 32'd4;
               end else if (flush) begin
                  state <= DROP;
                  pc    <= target;
               end
            end
            DROP: begin
               if (flush) pc <= target;
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifoData[i] <= 32'h0;
`ifdef HS32_FETCH_PC_EN
            fifoPc[i]   <= 32'h0;
`endif
         end
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            fifoData[wrPtr] <= mem_data;
`ifdef HS32_FETCH_PC_EN
            fifoPc[wrPtr]   <= mem_addr;
`endif
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) rdPtr <= rdPtr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   pushNotFull: assert property (@(posedge clk) disable iff (!reset) !(push && count == CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed self-checking bench for hs32_fetch; define HS32_FETCH_PC_EN to also exercise instpc.
module tb_hs32_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_data;
   logic [31:0] instd;
   logic        reqd;
   logic        ackd;
   logic        flush;
   logic [31:0] newpc;
`ifdef HS32_FETCH_PC_EN
   logic [31:0] instpc;
`endif

   int assertCount = 0;
   int failCount   = 0;

   hs32_fetch #(.DEPTH(4), .RESET_VEC(32'h0000_0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_addr (mem_addr),
      .mem_req  (mem_req),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .instd    (instd),
      .reqd     (reqd),
      .ackd     (ackd),
      .flush    (flush),
      .newpc    (newpc)
`ifdef HS32_FETCH_PC_EN
      ,
      .instpc   (instpc)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic f, input logic [31:0] np, input logic ack,
                                input logic [31:0] data, input logic rd);
      flush    = f;
      newpc    = np;
      mem_ack  = ack;
      mem_data = data;
      reqd     = rd;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Acknowledge the currently issued request with the given word, then drop ack.
   task automatic serve(input logic [31:0] data, input logic rd);
      applyStimulus(1'b0, 32'h0, 1'b1, data, rd);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, rd);
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Reset state and first two sequential fetches
      doReset();
      checkOutput("rst_req",  {31'h0, mem_req}, 32'h0);
      checkOutput("rst_ackd", {31'h0, ackd}, 32'h0);
      checkOutput("rst_addr", mem_addr, 32'h0);
      checkOutput("rst_instd", instd, 32'h0);
`ifdef HS32_FETCH_PC_EN
      checkOutput("rst_instpc", instpc, 32'h0);
`endif
      reqd = 1'b1;
      tick();
      checkOutput("t1_req0", {31'h0, mem_req}, 32'h1);
      checkOutput("t1_addr0", mem_addr, 32'h0);
      serve(32'h0A00_0001, 1'b1);
      checkOutput("t1_ackd0", {31'h0, ackd}, 32'h1);
      checkOutput("t1_instd0", instd, 32'h0A00_0001);
      checkOutput("t1_gap", {31'h0, mem_req}, 32'h0);
      tick();
      checkOutput("t1_addr1", mem_addr, 32'h4);
      checkOutput("t1_popped", {31'h0, ackd}, 32'h0);
      serve(32'h0B00_0002, 1'b1);
      checkOutput("t1_instd1", instd, 32'h0B00_0002);
      tick();
      checkOutput("t1_addr2", mem_addr, 32'h8);

      // Fill with decode stalled: exactly four requests, then the issue gate holds
      doReset();
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("t2_req", {31'h0, mem_req}, 32'h1);
         checkOutput("t2_addr", mem_addr, 32'(i * 4));
         serve(32'h1000 + 32'(i), 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t2_full_noreq", {31'h0, mem_req}, 32'h0);
      end
      checkOutput("t2_head", instd, 32'h1000);
      reqd = 1'b1;
      tick();
      checkOutput("t2_pop1", instd, 32'h1001);
      checkOutput("t2_still_idle", {31'h0, mem_req}, 32'h0);
      tick();
      checkOutput("t2_refill_req", {31'h0, mem_req}, 32'h1);
      checkOutput("t2_refill_addr", mem_addr, 32'h10);
      checkOutput("t2_pop2", instd, 32'h1002);

      // Flush while a request waits: response discarded, next fetch at newpc
      doReset();
      tick();
      serve(32'h1111_1111, 1'b0);
      tick();
      checkOutput("t3_pre_ackd", {31'h0, ackd}, 32'h1);
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("t3_flush_ackd", {31'h0, ackd}, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("t3_drop_req", {31'h0, mem_req}, 32'h1);
      checkOutput("t3_drop_addr", mem_addr, 32'h4);
      tick();
      tick();
      serve(32'hDEAD_BEEF, 1'b1);
      checkOutput("t3_discard_ackd", {31'h0, ackd}, 32'h0);
      checkOutput("t3_idle", {31'h0, mem_req}, 32'h0);
      tick();
      checkOutput("t3_new_addr", mem_addr, 32'h100);
      checkOutput("t3_new_req", {31'h0, mem_req}, 32'h1);
      checkOutput("t3_still_empty", {31'h0, ackd}, 32'h0);

      // Flush coinciding with mem_ack and a pop while two words are queued
      doReset();
      tick();
      serve(32'hA, 1'b0);
      tick();
      serve(32'hB, 1'b0);
      tick();
      checkOutput("t4_addr8", mem_addr, 32'h8);
      applyStimulus(1'b1, 32'h203, 1'b1, 32'hC, 1'b1);
      #1;
      checkOutput("t4_flush_ackd", {31'h0, ackd}, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("t4_empty", {31'h0, ackd}, 32'h0);
      tick();
      checkOutput("t4_new_addr", mem_addr, 32'h200);

      // Reset asserted while dropping a request after three words were queued
      doReset();
      for (int i = 0; i < 3; i++) begin
         tick();
         serve(32'h3000 + 32'(i), 1'b0);
      end
      tick();
      checkOutput("t5_queued", instd, 32'h3000);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      tick();
      checkOutput("t5_rst_req", {31'h0, mem_req}, 32'h0);
      checkOutput("t5_rst_ackd", {31'h0, ackd}, 32'h0);
      reset = 1'b1;
      tick();
      checkOutput("t5_recover_req", {31'h0, mem_req}, 32'h1);
      checkOutput("t5_recover_addr", mem_addr, 32'h0);

      // PC wraps past the top of the address space
      doReset();
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("t6_idle", {31'h0, mem_req}, 32'h0);
      tick();
      checkOutput("t6_top_addr", mem_addr, 32'hFFFF_FFFC);
      serve(32'h5, 1'b0);
      tick();
      checkOutput("t6_wrap_addr", mem_addr, 32'h0);

`ifdef HS32_FETCH_PC_EN
      // instpc tracks each word's fetch address after a redirect
      doReset();
      applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         serve(32'h7000 + 32'(i), 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         checkOutput("t7_instpc", instpc, 32'h200 + 32'(i * 4));
         checkOutput("t7_instd", instd, 32'h7000 + 32'(i));
         reqd = 1'b1;
         tick();
         reqd = 1'b0;
         #1;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
